pipe_spawn_scheduler: RTL and testbench

Sequences pipe obstacles for the game. Holds up to NUM_PIPES pipe slots, each with an x position and a gap y coordinate. On each frame tick it moves the active pipes left, retires the ones that leave the screen, and spawns a new pipe at a fixed interval. A new pipe's gap y is the sampled random_y value, clamped to a legal range. Sits between the random y counter (upstream, provides random_y) and the pipe renderer / collision logic (downstream, reads slots via pipe_sel).

---
 rtl/pipe_sched_pkg.sv | 36 +++
 rtl/pipe_slot.sv | 63 ++++++
 rtl/pipe_spawn_scheduler.sv | 168 ++++++++++++++++
 tb/tb_pipe_spawn_scheduler.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_sched_pkg.sv
// rtl/pipe_sched_pkg.sv - shared widths, state enum, slot struct and gap clamp for the pipe scheduler
package pipe_sched_pkg;

    localparam int X_W = 8;
    localparam int Y_W = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    typedef struct packed {
        logic           valid;
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } slot_t;

    // Keeps a spawned gap inside the playable band [lo, hi].
    function automatic logic [Y_W-1:0] clamp_y(
        input logic [Y_W-1:0] ry,
        input logic [Y_W-1:0] lo,
        input logic [Y_W-1:0] hi
    );
        logic [Y_W-1:0] r;
        if (ry < lo) begin
            r = lo;
        end else if (ry > hi) begin
            r = hi;
        end else begin
            r = ry;
        end
        return r;
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - one pipe slot register with move/retire/load on a frame tick
module pipe_slot
    import pipe_sched_pkg::*;
#(
    parameter int X_START = 159,
    parameter int SPEED   = 1,
    parameter int BIRD_X  = 40
) (
    input  logic           clk,
    input  logic           reset,       // synchronous, active-high
    input  logic           clear,       // scheduler leaving/sitting in IDLE
    input  logic           tick,        // frame tick accepted by the scheduler
    input  logic           load,        // this slot is the spawn target of the tick
    input  logic [Y_W-1:0] load_y,      // clamped gap for a spawn
    output logic           pre_valid_o, // valid bit before the tick
    output slot_t          slot_d_o,    // slot contents after the coming edge
    output logic           pass_o       // this slot crosses BIRD_X on this tick
);

    localparam logic [X_W-1:0] SPEED_X  = X_W'(SPEED);
    localparam logic [X_W-1:0] START_X  = X_W'(X_START);
    localparam logic [X_W-1:0] BIRD_X_X = X_W'(BIRD_X);

    slot_t          slot_q, slot_d;
    logic [X_W-1:0] moved_x;

    assign moved_x = slot_q.x - SPEED_X;

    always_comb begin
        slot_d = slot_q;
        pass_o = 1'b0;
        if (clear) begin
            slot_d = '0;
        end else if (tick) begin
            if (load) begin
                // A fresh pipe appears at X_START and is not moved on its spawn tick.
                slot_d.valid = 1'b1;
                slot_d.x     = START_X;
                slot_d.y     = load_y;
            end else if (slot_q.valid) begin
                if (slot_q.x >= SPEED_X) begin
                    slot_d.x = moved_x;
                    pass_o   = (slot_q.x >= BIRD_X_X) && (moved_x < BIRD_X_X);
                end else begin
                    // Off the left edge: retire instead of wrapping.
                    slot_d.valid = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign pre_valid_o = slot_q.valid;
    assign slot_d_o    = slot_d;

endmodule

// File: rtl/pipe_spawn_scheduler.sv
// rtl/pipe_spawn_scheduler.sv - pipe obstacle sequencer: FSM, spawn timing, pass counting, slot readout
module pipe_spawn_scheduler
    import pipe_sched_pkg::*;
#(
    parameter int NUM_PIPES    = 3,
    parameter int X_START      = 159,
    parameter int SPEED        = 1,
    parameter int SPAWN_FRAMES = 50,
    parameter int BIRD_X       = 40,
    parameter int Y_MIN        = 30,
    parameter int Y_MAX        = 100
) (
    input  logic           clk,
    input  logic           reset,       // synchronous, active-high
    input  logic           enable,      // game running
    input  logic           frame_tick,  // one pulse per video frame
    input  logic           collision,   // bird hit a pipe
    input  logic [Y_W-1:0] random_y,    // upstream random gap value
    input  logic [1:0]     pipe_sel,    // readout slot index
    output logic           pipe_valid,  // selected slot active (1-cycle latency)
    output logic [X_W-1:0] pipe_x,
    output logic [Y_W-1:0] pipe_y,
    output logic           spawn_pulse,
    output logic           drop_pulse,
    output logic           pass_pulse,
    output logic [7:0]     pass_count,
    output logic [1:0]     state_out
);

    localparam logic [7:0]     CNT_LAST = 8'(SPAWN_FRAMES - 1);
    localparam logic [Y_W-1:0] Y_LO     = Y_W'(Y_MIN);
    localparam logic [Y_W-1:0] Y_HI     = Y_W'(Y_MAX);

    state_e         state_q, state_d;
    logic [7:0]     cnt_q, cnt_d;
    logic [7:0]     pass_cnt_q, pass_cnt_d;
    logic           spawn_q, spawn_d;
    logic           drop_q, drop_d;
    logic           pass_q, pass_d;
    slot_t          rd_q, rd_d;

    slot_t          slot_d_arr [NUM_PIPES];
    logic [NUM_PIPES-1:0] pre_valid;
    logic [NUM_PIPES-1:0] pass_vec;
    logic [NUM_PIPES-1:0] load_vec;
    logic           tick_go;
    logic           clear_slots;
    logic           found;
    logic [Y_W-1:0] spawn_y;

    // State register transitions; leaving RUN for IDLE outranks collision.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (enable) state_d = ST_RUN;
            ST_RUN: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (collision) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: if (!enable) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // A collision in the same cycle as a tick swallows that tick.
    assign tick_go     = (state_q == ST_RUN) && enable && !collision && frame_tick;
    assign clear_slots = (state_d == ST_IDLE);
    assign spawn_y     = clamp_y(random_y, Y_LO, Y_HI);

    // Spawn timing and lowest-free-slot selection, using pre-tick valid bits
    // so a slot retiring on this tick is not reused until the next one.
    always_comb begin
        cnt_d    = cnt_q;
        load_vec = '0;
        found    = 1'b0;
        spawn_d  = 1'b0;
        drop_d   = 1'b0;
        if (clear_slots) begin
            cnt_d = CNT_LAST;
        end else if (tick_go) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                for (int i = 0; i < NUM_PIPES; i++) begin
                    if (!found && !pre_valid[i]) begin
                        load_vec[i] = 1'b1;
                        found       = 1'b1;
                    end
                end
                spawn_d = found;
                drop_d  = !found;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    // At most one pass per tick, however many slots cross together.
    always_comb begin
        pass_d     = tick_go && (|pass_vec);
        pass_cnt_d = pass_cnt_q;
        if ((state_q == ST_IDLE) && (state_d == ST_RUN)) begin
            pass_cnt_d = '0;
        end else if (pass_d && (pass_cnt_q != 8'hFF)) begin
            pass_cnt_d = pass_cnt_q + 8'd1;
        end
    end

    // Readout samples next-state slots so it matches the state after the edge.
    always_comb begin
        rd_d = '0;
        for (int i = 0; i < NUM_PIPES; i++) begin
            if (pipe_sel == 2'(i)) begin
                rd_d = slot_d_arr[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_PIPES; g++) begin : g_slot
        pipe_slot #(
            .X_START (X_START),
            .SPEED   (SPEED),
            .BIRD_X  (BIRD_X)
        ) u_slot (
            .clk         (clk),
            .reset       (reset),
            .clear       (clear_slots),
            .tick        (tick_go),
            .load        (load_vec[g]),
            .load_y      (spawn_y),
            .pre_valid_o (pre_valid[g]),
            .slot_d_o    (slot_d_arr[g]),
            .pass_o      (pass_vec[g])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= CNT_LAST;
            pass_cnt_q <= '0;
            spawn_q    <= 1'b0;
            drop_q     <= 1'b0;
            pass_q     <= 1'b0;
            rd_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pass_cnt_q <= pass_cnt_d;
            spawn_q    <= spawn_d;
            drop_q     <= drop_d;
            pass_q     <= pass_d;
            rd_q       <= rd_d;
        end
    end

    assign pipe_valid  = rd_q.valid;
    assign pipe_x      = rd_q.x;
    assign pipe_y      = rd_q.y;
    assign spawn_pulse = spawn_q;
    assign drop_pulse  = drop_q;
    assign pass_pulse  = pass_q;
    assign pass_count  = pass_cnt_q;
    assign state_out   = state_q;

endmodule

// File: tb/tb_pipe_spawn_scheduler.sv
// tb/tb_pipe_spawn_scheduler.sv - scoreboard bench with a behavioural pipe model
module tb_pipe_spawn_scheduler;

    localparam int NP    = 3;
    localparam int XS    = 159;
    localparam int SPD   = 1;
    localparam int SF    = 50;
    localparam int BX    = 40;
    localparam int YLO   = 30;
    localparam int YHI   = 100;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       frame_tick = 1'b0;
    logic       collision = 1'b0;
    logic [6:0] random_y = '0;
    logic [1:0] pipe_sel = '0;
    logic       pipe_valid;
    logic [7:0] pipe_x;
    logic [6:0] pipe_y;
    logic       spawn_pulse, drop_pulse, pass_pulse;
    logic [7:0] pass_count;
    logic [1:0] state_out;

    always #5 clk = ~clk;

    pipe_spawn_scheduler #(
        .NUM_PIPES(NP), .X_START(XS), .SPEED(SPD), .SPAWN_FRAMES(SF),
        .BIRD_X(BX), .Y_MIN(YLO), .Y_MAX(YHI)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .frame_tick(frame_tick),
        .collision(collision), .random_y(random_y), .pipe_sel(pipe_sel),
        .pipe_valid(pipe_valid), .pipe_x(pipe_x), .pipe_y(pipe_y),
        .spawn_pulse(spawn_pulse), .drop_pulse(drop_pulse), .pass_pulse(pass_pulse),
        .pass_count(pass_count), .state_out(state_out)
    );

    typedef struct {
        bit         check_xy;
        logic       valid;
        logic [7:0] x;
        logic [6:0] y;
        logic       sp, dr, pa;
        logic [7:0] pc;
        logic [1:0] st;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Model: mode 0 idle / 1 run / 2 halt; m_due counts ticks until next spawn attempt.
    int m_mode = 0;
    int m_due = 1;
    int m_passes = 0;
    int m_v[NP];
    int m_x[NP];
    int m_y[NP];

    task automatic model_clear();
        for (int i = 0; i < NP; i++) begin
            m_v[i] = 0; m_x[i] = 0; m_y[i] = 0;
        end
        m_due = 1;
    endtask

    task automatic model_step(input bit r, input bit e, input bit t, input bit c,
                              input int ry, input int sel);
        exp_t ex;
        bit sp = 0, dr = 0, pa = 0;
        int ov[NP];
        int tgt, nx;
        if (r) begin
            model_clear();
            m_mode = 0;
            m_passes = 0;
        end else if (m_mode == 0) begin
            if (e) begin
                m_mode = 1;
                m_passes = 0;
            end
        end else if (m_mode == 1) begin
            if (!e) begin
                m_mode = 0;
                model_clear();
            end else if (c) begin
                m_mode = 2;
            end else if (t) begin
                for (int i = 0; i < NP; i++) ov[i] = m_v[i];
                for (int i = 0; i < NP; i++) begin
                    if (ov[i] != 0) begin
                        if (m_x[i] >= SPD) begin
                            nx = m_x[i] - SPD;
                            if (m_x[i] >= BX && nx < BX) pa = 1;
                            m_x[i] = nx;
                        end else begin
                            m_v[i] = 0;
                        end
                    end
                end
                m_due = m_due - 1;
                if (m_due == 0) begin
                    m_due = SF;
                    tgt = -1;
                    for (int i = NP - 1; i >= 0; i--) if (ov[i] == 0) tgt = i;
                    if (tgt >= 0) begin
                        m_v[tgt] = 1;
                        m_x[tgt] = XS;
                        m_y[tgt] = (ry < YLO) ? YLO : ((ry > YHI) ? YHI : ry);
                        sp = 1;
                    end else begin
                        dr = 1;
                    end
                end
                if (pa) m_passes++;
            end
        end else begin
            if (!e) begin
                m_mode = 0;
                model_clear();
            end
        end
        ex.sp = sp; ex.dr = dr; ex.pa = pa;
        ex.pc = 8'((m_passes > 255) ? 255 : m_passes);
        ex.st = 2'(m_mode);
        if (sel < NP) begin
            ex.valid = (m_v[sel] != 0);
            ex.x = 8'(m_x[sel]);
            ex.y = 7'(m_y[sel]);
            ex.check_xy = (m_v[sel] != 0) || (m_mode == 0);
        end else begin
            ex.valid = 1'b0; ex.x = '0; ex.y = '0; ex.check_xy = 1;
        end
        exp_q.push_back(ex);
    endtask

    task automatic drive(input bit r, input bit e, input bit t, input bit c,
                         input int ry, input int sel);
        @(negedge clk);
        reset = r; enable = e; frame_tick = t; collision = c;
        random_y = 7'(ry); pipe_sel = 2'(sel);
        model_step(r, e, t, c, ry, sel);
    endtask

    exp_t mon_e;
    bit   mon_ok;
    always begin
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_ok = (pipe_valid === mon_e.valid) && (spawn_pulse === mon_e.sp) &&
                     (drop_pulse === mon_e.dr) && (pass_pulse === mon_e.pa) &&
                     (pass_count === mon_e.pc) && (state_out === mon_e.st) &&
                     (!mon_e.check_xy || ((pipe_x === mon_e.x) && (pipe_y === mon_e.y)));
            n_vec++;
            if (!mon_ok) begin
                n_bad++;
                $display("FAIL outputs t=%0t got v=%b x=%0d y=%0d sp=%b dr=%b pa=%b pc=%0d st=%0d required v=%b x=%0d y=%0d (xy_chk=%0d) sp=%b dr=%b pa=%b pc=%0d st=%0d",
                         $time, pipe_valid, pipe_x, pipe_y, spawn_pulse, drop_pulse, pass_pulse,
                         pass_count, state_out, mon_e.valid, mon_e.x, mon_e.y, mon_e.check_xy,
                         mon_e.sp, mon_e.dr, mon_e.pa, mon_e.pc, mon_e.st);
            end
        end
    end

    bit r_i, e_i, t_i, c_i;

    initial begin
        repeat (3) drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 1, 1, 0, 64, 0);
        for (int k = 0; k < 12; k++) drive(0, 1, (k % 2) == 0, 0, 10, 0);
        // Collision with a simultaneous tick, then ticks while halted.
        drive(0, 1, 1, 1, 120, 0);
        for (int k = 0; k < 10; k++) drive(0, 1, 1, 0, 50, k % 4);
        drive(0, 0, 1, 0, 50, 0);
        drive(0, 0, 0, 0, 50, 3);
        drive(0, 1, 0, 0, 50, 0);
        // Single pipe run to retirement with clamp at the upper bound.
        for (int k = 0; k < 170; k++) drive(0, 1, 1, 0, 120, 0);
        for (int k = 0; k < 8; k++) drive(0, 1, 1, 0, 5, 3);
        drive(1, 1, 1, 0, 5, 0);
        for (int c = 0; c < 9000; c++) begin
            r_i = ($urandom_range(0, 1999) == 0);
            if (m_mode == 2)      e_i = ($urandom_range(0, 39) != 0);
            else if (m_mode == 0) e_i = ($urandom_range(0, 9) != 0);
            else                  e_i = ($urandom_range(0, 1499) != 0);
            c_i = ($urandom_range(0, 1999) == 0);
            t_i = ($urandom_range(0, 2) == 0);
            drive(r_i, e_i, t_i, c_i, $urandom_range(0, 127), $urandom_range(0, 3));
        end
        repeat (3) @(negedge clk);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain got %0d pending required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
